fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the instruction-fetch stage of the pipeline. Owns the PC register,
//  issues one request at a time to a req/ack instruction memory with variable
//  wait states, and buffers returned words in a small FIFO toward decode
//  (valid/ready). Handles redirects from branch/jump resolution and flags
//  out-of-range or misaligned fetch addresses.
// PARAMETERS
//  ADDR_WIDTH   12       byte-address width of instruction memory window
//  ADDR_OFFSET  'h3000   base (reset) PC; window = [ADDR_OFFSET, ADDR_OFFSET+2**ADDR_WIDTH)
//  BUF_DEPTH    2        fetch FIFO entries (power of two, >=2)
// PORTS
//  clk            in   1   clock, all state on posedge
//  reset          in   1   synchronous, active-low reset
//  imem_req       out  1   fetch request; held high until imem_ack
//  imem_addr      out  32  fetch byte address; stable while imem_req high
//  imem_ack       in   1   memory response valid (may be same cycle as req)
//  imem_rdata     in   32  instruction word, valid with imem_ack
//  redirect_valid in   1   one-cycle pulse: flush and refetch from redirect_pc
//  redirect_pc    in   32  redirect target
//  out_valid      out  1   FIFO head valid toward decode
//  out_ready      in   1   decode accepts head this cycle
//  out_pc         out  32  PC of head instruction
//  out_instr      out  32  head instruction word
//  fetch_fault    out  1   PC outside window or pc[1:0]!=0; fetching halted
// BEHAVIOUR
//  - Reset (reset==0 at posedge): pc=ADDR_OFFSET, state=IDLE, FIFO empty, imem_req=0,
//    imem_addr=ADDR_OFFSET, out_valid=0, out_pc=0, out_instr=0, fetch_fault=0.
//    Reset mid-request aborts it; any later stale ack is ignored (state IDLE).
//  - States: IDLE, FETCH, DISCARD, FAULT.
//  - IDLE: exactly one cycle after reset release -> FETCH (or FAULT if pc invalid).
//  - FETCH: imem_req=1, imem_addr=pc whenever FIFO count<BUF_DEPTH (count sampled
//    at request start; req never drops before ack). On ack: push {pc,imem_rdata},
//    pc<=pc+4 (32-bit wrap irrelevant, caught by window check). Next pc invalid -> FAULT.
//  - Zero-wait memory + out_ready=1 sustains one instruction per cycle.
//  - FIFO: out_* driven from head; pop on out_valid&&out_ready; push+pop same cycle
//    allowed. No push ever occurs when full; no pop when empty.
//  - Redirect (priority over all else, any state except reset):
//    FIFO flushed (out_valid=0 next cycle; same-cycle pop ignored), pc<=redirect_pc.
//    If a request is outstanding and not acked this cycle -> DISCARD: keep req/addr
//    stable until ack, drop that data, then -> FETCH at new pc. Ack in same cycle
//    as redirect: data dropped. Redirect in DISCARD: update pc target, stay DISCARD.
//  - Redirect target invalid -> FAULT (after any DISCARD completes).
//  - FAULT: imem_req=0, fetch_fault=1, FIFO still drains to decode. Leaves only on
//    redirect to valid pc (fetch_fault=0 next cycle, -> FETCH) or reset.
//  - Valid pc: ADDR_OFFSET <= pc < ADDR_OFFSET+2**ADDR_WIDTH and pc[1:0]==0.
// TESTING
//  1 reset low 2 cyc then high, 0-wait mem, out_ready=1 -> imem_addr 3000,3004,3008..
//    one per cycle; first out_valid 2 cycles after release with out_pc=0x3000.
//  2 out_ready=0 -> 2 words buffered (3000,3004), req low, pc=3008; ready=1 ->
//    3000,3004,3008 in order, no loss or duplicate.
//  3 3-wait mem, redirect to 0x3100 during wait 1 -> req/addr held until ack, data
//    dropped, next imem_addr=0x3100, first out_pc=0x3100.
//  4 redirect_pc=0x3102 -> fetch_fault=1, imem_req=0; redirect 0x3200 ->
//    fetch_fault=0 next cycle, imem_addr=0x3200.
//  5 redirect 0x3FF8, run -> 3FF8,3FFC delivered, then fetch_fault=1, no req to 0x4000.
//  6 reset low during outstanding req with FIFO full -> next cycle all outputs at
//    reset values; stale ack ignored; restart at 0x3000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one req/ack fetch at a time,
// buffers returned words toward decode, and handles redirects and fetch faults.
module fetch_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] ADDR_OFFSET = 32'h3000,
  parameter int unsigned BUF_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [32:0] WIN_LO = {1'b0, ADDR_OFFSET};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(1) << ADDR_WIDTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    FAULT   = 2'd3
  } state_t;

  // Window and alignment test applied to every address before it is fetched.
  function automatic logic pc_valid(input logic [31:0] a);
    return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI) && (a[1:0] == 2'b00);
  endfunction

  state_t             state;
  logic [31:0]        pc;
  fetch_entry_t       mem [BUF_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               ack_hit;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   count_n;
  logic [PTR_W-1:0]   rd_ptr_n;
  logic [PTR_W-1:0]   wr_ptr_n;
  logic               space;
  logic [31:0]        pc_inc;
  logic               inc_ok;
  logic [31:0]        tgt;
  logic               tgt_ok;
  fetch_entry_t       new_entry;
  fetch_entry_t       head_n;

  // FIFO bookkeeping and next-head selection; a redirect flushes everything.
  always_comb begin
    ack_hit   = imem_req && imem_ack;
    push      = ack_hit && (state == FETCH) && !redirect_valid;
    pop       = out_valid && out_ready && !redirect_valid;
    count_n   = count;
    rd_ptr_n  = rd_ptr;
    wr_ptr_n  = wr_ptr;
    if (redirect_valid) begin
      count_n  = '0;
      rd_ptr_n = '0;
      wr_ptr_n = '0;
    end else begin
      count_n  = count + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_n = rd_ptr + PTR_W'(pop);
      wr_ptr_n = wr_ptr + PTR_W'(push);
    end
    space     = count_n < CNT_W'(BUF_DEPTH);
    pc_inc    = pc + 32'd4;
    inc_ok    = pc_valid(pc_inc);
    tgt       = redirect_valid ? redirect_pc : pc;
    tgt_ok    = pc_valid(tgt);
    new_entry = '{pc: pc, instr: imem_rdata};
    // Pushing into the slot that becomes head means the FIFO was empty after pop.
    head_n    = (push && (wr_ptr == rd_ptr_n)) ? new_entry : mem[rd_ptr_n];
  end

  // FIFO storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Fetch state machine, PC, FIFO pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= ADDR_OFFSET;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= ADDR_OFFSET;
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_instr   <= '0;
      fetch_fault <= 1'b0;
    end else begin
      count     <= count_n;
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      out_valid <= (count_n != '0);
      out_pc    <= head_n.pc;
      out_instr <= head_n.instr;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end

      case (state)
        IDLE: begin
          if (tgt_ok) begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= tgt;
          end else begin
            state       <= FAULT;
            imem_req    <= 1'b0;
            fetch_fault <= 1'b1;
          end
        end

        FETCH: begin
          if (redirect_valid) begin
            if (imem_req && !imem_ack) begin
              // Outstanding request must complete; its data will be dropped.
              state <= DISCARD;
            end else if (tgt_ok) begin
              imem_req  <= 1'b1;
              imem_addr <= tgt;
            end else begin
              state       <= FAULT;
              imem_req    <= 1'b0;
              fetch_fault <= 1'b1;
            end
          end else if (ack_hit) begin
            pc <= pc_inc;
            if (inc_ok) begin
              imem_req  <= space;
              imem_addr <= pc_inc;
            end else begin
              state       <= FAULT;
              imem_req    <= 1'b0;
              fetch_fault <= 1'b1;
            end
          end else if (!imem_req && space) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end

        DISCARD: begin
          // Request and address stay frozen until the stale response arrives.
          if (imem_ack) begin
            if (tgt_ok) begin
              state     <= FETCH;
              imem_req  <= 1'b1;
              imem_addr <= tgt;
            end else begin
              state       <= FAULT;
              imem_req    <= 1'b0;
              fetch_fault <= 1'b1;
            end
          end
        end

        FAULT: begin
          imem_req <= 1'b0;
          if (redirect_valid && tgt_ok) begin
            state       <= FETCH;
            imem_req    <= 1'b1;
            imem_addr   <= tgt;
            fetch_fault <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: wait-state memory model, directed
// scenarios, randomized redirects/back-pressure, scoreboard of expected PCs.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;
  int deliv = 0;

  // memory model controls
  int   wait_fix = 0;
  int   wait_cur = 0;
  int   wcnt = 0;
  logic rand_wait = 1'b0;
  logic stray_ack = 1'b0;

  // scoreboard: every PC decode should still see, in order
  logic [31:0] exp_q[$];
  logic        fault_seg = 1'b0;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic addr_ok(input logic [31:0] a);
    return (a >= 32'h3000) && (a < 32'h4000) && (a[1:0] == 2'b00);
  endfunction

  assign imem_ack   = (imem_req && (wcnt >= wait_cur)) || stray_ack;
  assign imem_rdata = word_of(imem_addr);

  // Wait-state counter; wait length for the next request chosen at each ack.
  always @(posedge clk) begin
    if (!reset) begin
      wcnt     <= 0;
      wait_cur <= wait_fix;
    end else if (imem_req && imem_ack) begin
      wcnt     <= 0;
      wait_cur <= rand_wait ? int'($urandom_range(0, 3)) : wait_fix;
    end else if (imem_req) begin
      wcnt <= wcnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // New fetch stream: everything from target up to the end of the window.
  task automatic seg_start(input logic [31:0] target);
    exp_q.delete();
    fault_seg = !addr_ok(target);
    if (!fault_seg) begin
      for (logic [31:0] a = target; a < 32'h4000; a += 32'd4) exp_q.push_back(a);
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    seg_start(target);
    step(1);
    redirect_valid = 1'b0;
  endtask

  // Monitor: deliveries against scoreboard, plus request protocol rules.
  logic        p_req = 1'b0, p_ack = 1'b0, p_rst = 1'b0;
  logic [31:0] p_addr = '0;
  always @(negedge clk) begin
    if (reset) begin
      if (imem_req) check("req_addr_in_window", 32'(addr_ok(imem_addr)), 32'd1);
      if (p_rst && p_req && !p_ack) begin
        check("req_held_until_ack", 32'(imem_req), 32'd1);
        check("addr_stable_while_req", imem_addr, p_addr);
      end
      if (out_valid && out_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_delivery_pc", out_pc, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("deliver_pc", out_pc, e);
          check("deliver_instr", out_instr, word_of(e));
        end
        deliv++;
      end
    end
    p_req  = imem_req;
    p_ack  = imem_ack;
    p_addr = imem_addr;
    p_rst  = reset;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"},    32'(imem_req),    32'd0);
    check({tag, "_imem_addr"},   imem_addr,        32'h3000);
    check({tag, "_out_valid"},   32'(out_valid),   32'd0);
    check({tag, "_out_pc"},      out_pc,           32'd0);
    check({tag, "_out_instr"},   out_instr,        32'd0);
    check({tag, "_fetch_fault"}, 32'(fetch_fault), 32'd0);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] idx;
    idx = 32'($urandom_range(0, 1023));
    case ($urandom_range(0, 7))
      0:       return 32'h3000 + (idx << 2) + 32'($urandom_range(1, 3));
      1:       return ($urandom_range(0, 1) == 0) ? 32'h2FFC : 32'h4000 + (idx << 2);
      2:       return 32'h3FE0 + (32'($urandom_range(0, 7)) << 2);
      default: return 32'h3000 + (idx << 2);
    endcase
  endfunction

  initial begin
    int d0;
    logic [31:0] q0, a0, a_hold;
    logic found;

    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    step(2);
    check_reset_outputs("reset");

    // start-up latency and one-per-cycle streaming
    reset = 1'b1;
    seg_start(32'h3000);
    step(1);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h3000);
    check("no_valid_yet", 32'(out_valid), 32'd0);
    step(1);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_out_pc", out_pc, 32'h3000);
    a0 = imem_addr;
    step(1);
    check("addr_increment", imem_addr, a0 + 32'd4);
    d0 = deliv;
    step(20);
    check("throughput_20", 32'(deliv - d0), 32'd20);

    // back-pressure fills the buffer, then drains in order
    out_ready = 1'b0;
    q0 = exp_q[0];
    step(6);
    check("stall_req_low", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_head", out_pc, q0);
    out_ready = 1'b1;
    step(1);
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", imem_addr, q0 + 32'd8);
    step(10);

    // redirect while a slow request is in its first wait cycle
    wait_fix = 3;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1);
      if (imem_req && !imem_ack && wcnt == 1) found = 1'b1;
    end
    check("wait1_found", 32'(found), 32'd1);
    a_hold = imem_addr;
    redirect(32'h3100);
    check("discard_req_held", 32'(imem_req), 32'd1);
    check("discard_addr_held", imem_addr, a_hold);
    check("discard_flush", 32'(out_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && imem_addr == 32'h3100) found = 1'b1; else step(1);
    end
    check("refetch_3100", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (out_valid) found = 1'b1;
    end
    check("first_after_redirect_seen", 32'(found), 32'd1);
    check("first_after_redirect_pc", out_pc, 32'h3100);
    wait_fix = 0;
    step(10);

    // misaligned redirect faults, valid redirect recovers
    redirect(32'h3102);
    step(5);
    check("misalign_fault", 32'(fetch_fault), 32'd1);
    check("misalign_req_low", 32'(imem_req), 32'd0);
    step(5);
    check("fault_drained", 32'(out_valid), 32'd0);
    redirect(32'h3200);
    check("recover_fault_clear", 32'(fetch_fault), 32'd0);
    check("recover_req", 32'(imem_req), 32'd1);
    check("recover_addr", imem_addr, 32'h3200);
    step(5);

    // run off the end of the window
    redirect(32'h3FF8);
    d0 = deliv;
    step(15);
    check("end_delivered", 32'(deliv - d0), 32'd2);
    check("end_fault", 32'(fetch_fault), 32'd1);
    check("end_req_low", 32'(imem_req), 32'd0);

    // reset during an outstanding request, stray ack afterwards
    out_ready = 1'b0;
    wait_fix = 3;
    redirect(32'h3000);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1);
      if (imem_req && !imem_ack && out_valid) found = 1'b1;
    end
    check("outstanding_found", 32'(found), 32'd1);
    reset = 1'b0;
    stray_ack = 1'b1;
    step(1);
    check_reset_outputs("midreset");
    reset = 1'b1;
    seg_start(32'h3000);
    step(1);
    stray_ack = 1'b0;
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", imem_addr, 32'h3000);
    check("stray_ignored", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    wait_fix = 0;
    d0 = deliv;
    step(20);
    check("restart_progress", 32'(deliv > d0), 32'd1);

    // randomized redirects, wait states and back-pressure
    rand_wait = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        logic [31:0] t;
        t = rand_target();
        redirect_valid = 1'b1;
        redirect_pc    = t;
        seg_start(t);
      end else begin
        redirect_valid = 1'b0;
      end
      step(1);
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    rand_wait = 1'b0;
    step(40);
    check("random_fault_state", 32'(fetch_fault), 32'(fault_seg || exp_q.size() == 0));

    redirect(32'h3FF0);
    d0 = deliv;
    step(30);
    check("final_delivered", 32'(deliv - d0), 32'd4);
    check("final_fault", 32'(fetch_fault), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
